// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RISC-V pipeline: EX forwarding selects,
// load-use / branch / memory-wait stall and flush control, wait timeout and perf counters.
module hazard_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int              WC_W      = $clog2(WAIT_MAX + 1);
    localparam logic [WC_W-1:0] WCNT_LAST = WC_W'(WAIT_MAX);

    typedef enum logic [1:0] {RUN, MEMWAIT, FAULT} state_t;

    state_t           state_q, state_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lw_stall;
    logic mem_stall;

    // Memory stage wins over Writeback; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_m, input logic we_m,
                                           input logic [4:0] rd_w, input logic we_w);
        if (we_m && (rd_m != 5'd0) && (rd_m == rs))
            return 2'b10;
        else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

    assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_stall = MemReqM && !MemReadyM;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        timeout_d = timeout_q;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;

        if (state_q == FAULT || mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else if (PCSrcE) begin
            // A taken branch squashes the dependent instruction, so no load-use stall.
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushE = lw_stall;
        end

        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEMWAIT;
                    wcnt_d  = WC_W'(1);
                end
            end
            MEMWAIT: begin
                if (mem_stall) begin
                    if (wcnt_q == WCNT_LAST) begin
                        state_d   = FAULT;
                        timeout_d = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end else begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && (state_q != FAULT) && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (FlushD && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            wcnt_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign MemTimeout = timeout_q;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: combinational vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_hazard_ctrl;

    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 3;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, MemTimeout;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [CNT_W-1:0] StallCount, FlushCount;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemTimeout(MemTimeout), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic [1:0] rsrc;
        logic       pcsrc;
        logic [4:0] rdm;
        logic       rwm;
        logic [4:0] rdw;
        logic       rww;
        logic [1:0] fa, fb;
        logic       stl, fld, fle;
    } vec_t;

    vec_t tbl [11];

    // Behavioural model state: fault flag, length of the current memory wait, counters.
    bit m_fault;
    int m_wait;
    int m_sc, m_fc;
    bit e_sf, e_sd, e_se, e_sm, e_fd, e_fe;
    logic [1:0] e_fa, e_fb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clr_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        m_fault = 0; m_wait = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic chk_stalls(input string nm, input logic [3:0] exp);
        chk({nm, "_stalls"}, 32'({StallF, StallD, StallE, StallM}), 32'(exp));
    endtask

    task automatic chk_flush(input string nm, input logic [1:0] exp);
        chk({nm, "_flush"}, 32'({FlushD, FlushE}), 32'(exp));
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_eval();
        bit lw, ms;
        lw = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        ms = MemReqM && !MemReadyM;
        e_fa = ref_fwd(Rs1E);
        e_fb = ref_fwd(Rs2E);
        {e_sf, e_sd, e_se, e_sm, e_fd, e_fe} = '0;
        if (m_fault || ms) begin
            {e_sf, e_sd, e_se, e_sm} = 4'hF;
        end else if (PCSrcE) begin
            e_fd = 1; e_fe = 1;
        end else begin
            e_sf = lw; e_sd = lw; e_fe = lw;
        end
    endtask

    task automatic model_advance();
        bit ms;
        ms = MemReqM && !MemReadyM;
        if (e_sf && !m_fault) m_sc = (m_sc < CNT_MAX) ? m_sc + 1 : m_sc;
        if (e_fd)             m_fc = (m_fc < CNT_MAX) ? m_fc + 1 : m_fc;
        if (!m_fault) begin
            if (ms) begin
                m_wait++;
                if (m_wait > WAIT_MAX) m_fault = 1;
            end else begin
                m_wait = 0;
            end
        end
    endtask

    task automatic chk_model();
        model_eval();
        chk("rnd_fwdA", 32'(ForwardAE), 32'(e_fa));
        chk("rnd_fwdB", 32'(ForwardBE), 32'(e_fb));
        chk("rnd_stalls", 32'({StallF, StallD, StallE, StallM}), 32'({e_sf, e_sd, e_se, e_sm}));
        chk("rnd_flush", 32'({FlushD, FlushE}), 32'({e_fd, e_fe}));
        chk("rnd_timeout", 32'(MemTimeout), 32'(m_fault));
        chk("rnd_scount", 32'(StallCount), 32'(m_sc));
        chk("rnd_fcount", 32'(FlushCount), 32'(m_fc));
    endtask

    initial begin
        //              rs1d rs2d rs1e rs2e rde rsrc pc rdm rwm rdw rww  fa    fb   stl fld fle
        tbl[0]  = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
        tbl[1]  = '{0, 0, 5, 0, 0, 2'b00, 0, 5, 1, 5, 1, 2'b10, 2'b00, 0, 0, 0};
        tbl[2]  = '{0, 0, 5, 0, 0, 2'b00, 0, 5, 0, 5, 1, 2'b01, 2'b00, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0, 0};
        tbl[4]  = '{0, 0, 9, 7, 0, 2'b00, 0, 7, 1, 9, 1, 2'b01, 2'b10, 0, 0, 0};
        tbl[5]  = '{0, 3, 0, 0, 3, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1};
        tbl[6]  = '{0, 3, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
        tbl[7]  = '{3, 0, 0, 0, 3, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1};
        tbl[9]  = '{4, 0, 0, 0, 4, 2'b01, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1};
        tbl[10] = '{0, 0, 6, 6, 0, 2'b00, 0, 6, 1, 6, 1, 2'b10, 2'b10, 0, 0, 0};

        clr_inputs();
        reset = 1'b1;
        #12;
        chk("reset_stalls", 32'({StallF, StallD, StallE, StallM}), 32'(0));
        chk("reset_flush", 32'({FlushD, FlushE}), 32'(0));
        chk("reset_fwd", 32'({ForwardAE, ForwardBE}), 32'(0));
        chk("reset_timeout", 32'(MemTimeout), 32'(0));
        chk("reset_counts", 32'({StallCount, FlushCount}), 32'(0));
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            Rs1D = tbl[i].rs1d; Rs2D = tbl[i].rs2d; Rs1E = tbl[i].rs1e; Rs2E = tbl[i].rs2e;
            RdE = tbl[i].rde; ResultSrcE = tbl[i].rsrc; PCSrcE = tbl[i].pcsrc;
            RdM = tbl[i].rdm; RegWriteM = tbl[i].rwm; RdW = tbl[i].rdw; RegWriteW = tbl[i].rww;
            #1;
            chk($sformatf("vec%0d_fwdA", i), 32'(ForwardAE), 32'(tbl[i].fa));
            chk($sformatf("vec%0d_fwdB", i), 32'(ForwardBE), 32'(tbl[i].fb));
            chk($sformatf("vec%0d_stall", i), 32'({StallF, StallD, StallE, StallM}),
                32'({tbl[i].stl, tbl[i].stl, 2'b00}));
            chk($sformatf("vec%0d_flush", i), 32'({FlushD, FlushE}), 32'({tbl[i].fld, tbl[i].fle}));
        end

        // Load-use for one cycle, then a taken branch for one cycle.
        clr_inputs();
        do_reset();
        ResultSrcE = 2'b01; RdE = 3; Rs2D = 3;
        #1;
        chk_stalls("lu", 4'b1100);
        chk_flush("lu", 2'b01);
        @(negedge clk);
        clr_inputs();
        PCSrcE = 1;
        #1;
        chk("lu_scount", 32'(StallCount), 32'(1));
        chk_stalls("br", 4'b0000);
        chk_flush("br", 2'b11);
        @(negedge clk);
        PCSrcE = 0;
        #1;
        chk("br_fcount", 32'(FlushCount), 32'(1));
        chk("br_scount", 32'(StallCount), 32'(1));

        // Three-cycle memory wait, then release.
        do_reset();
        MemReqM = 1; MemReadyM = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_stalls($sformatf("mw%0d", c), 4'b1111);
            @(negedge clk);
        end
        MemReadyM = 1;
        #1;
        chk_stalls("mw_rel", 4'b0000);
        @(negedge clk);
        #1;
        chk("mw_scount", 32'(StallCount), 32'(3));
        chk_stalls("mw_run", 4'b0000);

        // Same wait with a taken branch held in Execute.
        clr_inputs();
        do_reset();
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_flush($sformatf("mwb%0d", c), 2'b00);
            @(negedge clk);
        end
        MemReadyM = 1;
        #1;
        chk_flush("mwb_rel", 2'b11);
        chk_stalls("mwb_rel", 4'b0000);
        @(negedge clk);
        clr_inputs();
        #1;
        chk("mwb_fcount", 32'(FlushCount), 32'(1));

        // Timeout: WAIT_MAX+1 stalled cycles, then sticky fault.
        do_reset();
        MemReqM = 1; MemReadyM = 0;
        for (int c = 0; c <= WAIT_MAX; c++) begin
            #1;
            chk_stalls($sformatf("to%0d", c), 4'b1111);
            chk($sformatf("to%0d_flag", c), 32'(MemTimeout), 32'(0));
            @(negedge clk);
        end
        MemReqM = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("fault%0d_flag", c), 32'(MemTimeout), 32'(1));
            chk_stalls($sformatf("fault%0d", c), 4'b1111);
            chk($sformatf("fault%0d_scount", c), 32'(StallCount), 32'(WAIT_MAX + 1));
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        chk_stalls("fault_rst", 4'b0000);
        chk_flush("fault_rst", 2'b00);
        chk("fault_rst_flag", 32'(MemTimeout), 32'(0));
        chk("fault_rst_counts", 32'({StallCount, FlushCount}), 32'(0));
        reset = 1'b0;

        // Counter saturation with ten back-to-back load-use stalls.
        do_reset();
        ResultSrcE = 2'b01; RdE = 8; Rs1D = 8;
        repeat (10) @(negedge clk);
        #1;
        chk("sat_scount", 32'(StallCount), 32'(CNT_MAX));

        // Randomized traffic against the model, with occasional resets.
        clr_inputs();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                #1;
                reset = 1'b0;
                m_fault = 0; m_wait = 0; m_sc = 0; m_fc = 0;
            end
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE    = ($urandom_range(0, 3) == 0);
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            MemReqM   = ($urandom_range(0, 2) == 0) || (m_wait > 0 && $urandom_range(0, 3) != 0);
            MemReadyM = ($urandom_range(0, 2) == 0);
            #1;
            chk_model();
            model_advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It generates the forwarding selects for the Execute stage and the stall/flush controls for the IF/ID, ID/EX and EX/MEM pipeline registers. It detects load-use hazards, taken branches/jumps and data-memory wait states. A small state machine tracks multi-cycle memory waits, enforces a timeout, and keeps saturating stall/flush performance counters.

## Interface
- WAIT_MAX, 15: maximum consecutive memory-wait cycles before a fault is declared (≥1).
- CNT_W, 32: width of the performance counters.

- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- Rs1D, Rs2D  in  5  source register numbers of the instruction in Decode (InstrD[19:15], InstrD[24:20])
- Rs1E, Rs2E, RdE  in  5  source and destination register numbers in Execute
- ResultSrcE  in  2  result select in Execute; 2'b01 = load
- PCSrcE  in  1  branch taken or jump in Execute
- RdM  in  5, RegWriteM  in  1  destination register and write enable in Memory
- RdW  in  5, RegWriteW  in  1  destination register and write enable in Writeback
- MemReqM  in  1  load/store in Memory requests data memory
- MemReadyM  in  1  data memory completes this cycle
- StallF, StallD, StallE, StallM  out  1  hold PC, IF/ID, ID/EX and EX/MEM respectively
- FlushD, FlushE  out  1  synchronous clear of IF/ID and ID/EX
- ForwardAE, ForwardBE  out  2  SrcA/SrcB select: 00 = RD1E/RD2E, 01 = ResultW, 10 = ALUResultM
- MemTimeout  out  1  sticky fault flag
- StallCount, FlushCount  out  CNT_W  saturating performance counters

## Operation
- **Forwarding (combinational)**
  - ForwardAE = 10 if RegWriteM && RdM≠0 && RdM==Rs1E.
  - Otherwise ForwardAE = 01 if RegWriteW && RdW≠0 && RdW==Rs1E.
  - Otherwise ForwardAE = 00.
  - ForwardBE follows the same rule using Rs2E. The Memory stage has priority over Writeback.
- **Hazard terms**
  - lwStall = (ResultSrcE==01) && RdE≠0 && (RdE==Rs1D || RdE==Rs2D).
  - memStall = MemReqM && !MemReadyM.
- **States:** RUN, MEMWAIT, FAULT. The wait counter wcnt is 0..WAIT_MAX.
- **RUN**
  - If memStall: StallF = StallD = StallE = StallM = 1, FlushD = FlushE = 0. Next state MEMWAIT, wcnt ← 1.
  - Otherwise: StallF = StallD = lwStall, StallE = StallM = 0, FlushD = PCSrcE, FlushE = lwStall | PCSrcE.
  - If PCSrcE and lwStall are both high (not architecturally possible), PCSrcE wins: StallF = StallD = 0, FlushD = FlushE = 1.
- **MEMWAIT**
  - If memStall: all four stalls are 1 and both flushes are 0.
    - If wcnt==WAIT_MAX, next state FAULT.
    - Otherwise wcnt ← wcnt + 1.
  - If !memStall (ready arrives or the request drops), outputs follow the RUN non-memStall rules this cycle, next state RUN, wcnt ← 0.
  - A taken branch held in Execute during the wait keeps PCSrcE high. Its flush is therefore applied in the release cycle; no separate pending register is needed.
- **FAULT**
  - All four stalls are 1, both flushes are 0, MemTimeout = 1.
  - Only reset exits this state.
- **Counters**
  - StallCount increments on each cycle with StallF==1 in RUN or MEMWAIT; it does not count in FAULT.
  - FlushCount increments on each cycle with FlushD==1.
  - Both counters saturate at all-ones.

## Timing
- **Reset** (asynchronous, takes effect immediately):
  - state = RUN, wcnt = 0, MemTimeout = 0, StallCount = FlushCount = 0.
  - With all inputs at 0, every combinational output is 0.
- Forwarding, stall and flush outputs are combinational from the current inputs and state, with zero-cycle latency.
- The state, wcnt, MemTimeout and counters update on the rising edge of clk.
- A memory wait of N cycles (MemReadyM low for N cycles while MemReqM is high) gives N stall cycles. MemReadyM high in the first cycle gives no stall.
- FAULT is entered when MemReadyM is still low in the cycle where wcnt==WAIT_MAX. That means WAIT_MAX + 1 consecutive stalled cycles; MemTimeout rises on the following edge.
- Reset asserted during MEMWAIT or FAULT returns the block to RUN immediately. The counters are cleared.

## Test plan
- **Forwarding:** RdM = RdW = Rs1E = 5, RegWriteM = RegWriteW = 1 → ForwardAE = 10. Then RegWriteM = 0 → 01. Then RdM = RdW = 0 with Rs1E = 0 → 00.
- **Load-use:** ResultSrcE = 01, RdE = 3, Rs2D = 3 → StallF = StallD = FlushE = 1 for one cycle, StallCount = 1. Same stimulus with RdE = 0 → no stall.
- **Taken branch:** PCSrcE = 1 for one cycle → FlushD = FlushE = 1, FlushCount = 1, no stall.
- **Memory wait:** MemReqM = 1, MemReadyM low for 3 cycles then high → StallF..StallM = 1 for exactly 3 cycles, state returns to RUN, StallCount = 3. Repeat with PCSrcE held high → flushes stay 0 during the wait, then FlushD = FlushE = 1 in the release cycle.
- **Timeout:** WAIT_MAX = 4, MemReadyM held low → 5 stalled cycles, then MemTimeout = 1 and stalls stay high. StallCount stops at 5. Reset asserted → all outputs return to 0.
- **Saturation:** CNT_W = 3, 10 consecutive load-use stalls → StallCount holds at 7.
